// File: rtl/chroma_pkg.sv
// chroma_pkg
// Shared geometry constants, the block FSM state type and small pixel helpers
// for the chroma 4x4 -> 8x8 upsampler.
//   PIX_W   : bits per chroma sample
//   DS_DIM  : side of the subsampled block (4)
//   BLK_DIM : side of the upsampled block (8)
//   DS_W    : packed width of a subsampled block (128)
//   BLK_W   : packed width of an upsampled block (512)
//   ROW_W   : packed width of one upsampled row (64)
package chroma_pkg;

    localparam int PIX_W   = 8;
    localparam int DS_DIM  = 4;
    localparam int BLK_DIM = 8;
    localparam int DS_W    = 128;
    localparam int BLK_W   = 512;
    localparam int ROW_W   = BLK_DIM * PIX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Element (i,j) of a packed 4x4 block; element (0,0) sits in the MSBs.
    function automatic logic [PIX_W-1:0] ds_pix(input logic [DS_W-1:0] blk,
                                                input logic [1:0]      i,
                                                input logic [1:0]      j);
        return blk[DS_W-1-PIX_W*(DS_DIM*int'(i)+int'(j)) -: PIX_W];
    endfunction

    // Neighbour index clamped at the block edge: min(i+1, 3).
    function automatic logic [1:0] clamp_next(input logic [1:0] i);
        return (i == 2'd3) ? 2'd3 : i + 2'd1;
    endfunction

endpackage

// File: rtl/chroma_upsample_row.sv
// chroma_upsample_row
// Combinational generator of one 8-sample output row from a captured 4x4
// chroma block. Replication by default; bilinear interpolation with edge
// clamping when the macro CHROMA_BILINEAR_EN is defined.
// Ports:
//   ds_blk  : captured 4x4 block, element (i,j) at [127-8*(4i+j) -: 8]
//   row_idx : output row number 0..7
//   row_out : output row, column c at [63-8*c -: 8]
module chroma_upsample_row
    import chroma_pkg::*;
(
    input  logic [DS_W-1:0]  ds_blk,
    input  logic [2:0]       row_idx,
    output logic [ROW_W-1:0] row_out
);

    logic [1:0] sr;
    assign sr = row_idx[2:1];

`ifdef CHROMA_BILINEAR_EN
    logic [1:0] sr1;
    assign sr1 = clamp_next(sr);
`else
    // Vertical phase is irrelevant when rows are simply duplicated.
    logic unused_row_lsb;
    assign unused_row_lsb = row_idx[0];
`endif

    generate
        for (genvar gi = 0; gi < BLK_DIM; gi++) begin : g_col
            localparam logic [1:0] SC = 2'(gi / 2);
`ifdef CHROMA_BILINEAR_EN
            localparam logic [1:0] SC1    = (SC == 2'd3) ? 2'd3 : SC + 2'd1;
            localparam bit         H_ODD  = (gi % 2) == 1;
            logic [9:0] a, b, c, d;
            logic [PIX_W-1:0] pix;

            // 10-bit sums: worst case 4*255+2 = 1022, and the rounded mean
            // of 8-bit samples can never exceed 255.
            always_comb begin
                a = {2'b00, ds_pix(ds_blk, sr,  SC)};
                b = {2'b00, ds_pix(ds_blk, sr,  SC1)};
                c = {2'b00, ds_pix(ds_blk, sr1, SC)};
                d = {2'b00, ds_pix(ds_blk, sr1, SC1)};
                pix = a[PIX_W-1:0];
                if (row_idx[0] && H_ODD)
                    pix = 8'((a + b + c + d + 10'd2) >> 2);
                else if (row_idx[0])
                    pix = 8'((a + c + 10'd1) >> 1);
                else if (H_ODD)
                    pix = 8'((a + b + 10'd1) >> 1);
            end

            assign row_out[ROW_W-1-PIX_W*gi -: PIX_W] = pix;
`else
            assign row_out[ROW_W-1-PIX_W*gi -: PIX_W] = ds_pix(ds_blk, sr, SC);
`endif
        end
    endgenerate

endmodule

// File: rtl/chrominance_upsampling.sv
// chrominance_upsampling
// Upsamples a 4x4 Cb/Cr block pair to 8x8, one output row per clock.
// A block is captured on an IDLE edge with Enable0 high; the next 8 edges
// write rows 0..7, the last of which raises enable1 for one cycle (DONE),
// after which the block returns to IDLE.
// Interpolation mode macro: CHROMA_BILINEAR_EN (defined = bilinear,
// undefined = replication). Timing is identical in both modes.
// Ports:
//   Clock   : clock, rising edge
//   reset   : asynchronous active-low reset
//   Enable0 : start request, sampled only in IDLE
//   Cb_s/Cr_s : 4x4 subsampled chroma inputs (128 bits)
//   Cb_u/Cr_u : 8x8 upsampled chroma outputs (512 bits), row 0 in the MSBs
//   busy    : high in RUN and DONE
//   enable1 : one-cycle block-complete pulse
module chrominance_upsampling
    import chroma_pkg::*;
(
    input  logic             Clock,
    input  logic             reset,
    input  logic             Enable0,
    input  logic [DS_W-1:0]  Cb_s,
    input  logic [DS_W-1:0]  Cr_s,
    output logic [BLK_W-1:0] Cb_u,
    output logic [BLK_W-1:0] Cr_u,
    output logic             busy,
    output logic             enable1
);

    state_t           state_reg, state_next;
    logic [2:0]       row_reg;
    logic [DS_W-1:0]  cb_cap_reg, cr_cap_reg;
    logic [ROW_W-1:0] cb_rows_reg [BLK_DIM];
    logic [ROW_W-1:0] cr_rows_reg [BLK_DIM];
    logic             enable1_reg;
    logic [ROW_W-1:0] cb_row, cr_row;

    // Row generators work from the captured copies so input changes during
    // a block cannot leak into it.
    chroma_upsample_row u_cb_row (
        .ds_blk  (cb_cap_reg),
        .row_idx (row_reg),
        .row_out (cb_row)
    );

    chroma_upsample_row u_cr_row (
        .ds_blk  (cr_cap_reg),
        .row_idx (row_reg),
        .row_out (cr_row)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (Enable0) state_next = RUN;
            RUN:     if (row_reg == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            row_reg     <= 3'd0;
            cb_cap_reg  <= '0;
            cr_cap_reg  <= '0;
            enable1_reg <= 1'b0;
            for (int r = 0; r < BLK_DIM; r++) begin
                cb_rows_reg[r] <= '0;
                cr_rows_reg[r] <= '0;
            end
        end else begin
            state_reg   <= state_next;
            enable1_reg <= (state_reg == RUN) && (row_reg == 3'd7);
            case (state_reg)
                IDLE: begin
                    if (Enable0) begin
                        cb_cap_reg <= Cb_s;
                        cr_cap_reg <= Cr_s;
                        row_reg    <= 3'd0;
                    end
                end
                RUN: begin
                    cb_rows_reg[row_reg] <= cb_row;
                    cr_rows_reg[row_reg] <= cr_row;
                    row_reg              <= row_reg + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state_reg != IDLE);
    assign enable1 = enable1_reg;

    generate
        for (genvar gi = 0; gi < BLK_DIM; gi++) begin : g_out
            assign Cb_u[BLK_W-1-ROW_W*gi -: ROW_W] = cb_rows_reg[gi];
            assign Cr_u[BLK_W-1-ROW_W*gi -: ROW_W] = cr_rows_reg[gi];
        end
    endgenerate

endmodule
